// File: rtl/loop_cnt_monitor.sv
`default_nettype none
// ============================================================================
// Module   : loop_cnt_monitor
// Purpose  : Consumer-side checker for a free-running 0..MAX_VAL loop counter.
//            Locks onto the wrap sequence and then counts laps (MAX_VAL->0
//            wraps) and sequence errors. All outputs are registered.
// Revision : 1.0 - initial release
// ============================================================================
module loop_cnt_monitor #(
    parameter int CNT_W    = 7,
    parameter int MAX_VAL  = 99,
    parameter int SYNC_LEN = 4,
    parameter int LAP_W    = 8,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cnt_in,
    input  logic             sample_en,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic             lap_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [LAP_W-1:0] lap_cnt
);

    localparam int               MATCH_W     = $clog2(SYNC_LEN + 1);
    localparam logic [CNT_W-1:0] C_MAX       = CNT_W'(MAX_VAL);
    localparam logic [MATCH_W-1:0] C_LAST_MATCH = MATCH_W'(SYNC_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_TRACK = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_exp;
    logic [MATCH_W-1:0] r_match;

    logic               w_in_range;
    logic               w_hit;
    logic [CNT_W-1:0]   w_nxt;

    // Expected successor of the current sample; exp is always in range, so a
    // hit can only happen for an in-range sample.
    assign w_in_range = (cnt_in <= C_MAX);
    assign w_nxt      = (cnt_in == C_MAX) ? '0 : cnt_in + 1'b1;
    assign w_hit      = w_in_range && (cnt_in == r_exp);

    // Lock/track state machine with registered flags, pulses and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_exp     <= '0;
            r_match   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            lap_pulse <= 1'b0;
            err_cnt   <= '0;
            lap_cnt   <= '0;
        end else begin
            err_pulse <= 1'b0;
            lap_pulse <= 1'b0;
            if (clr) begin
                r_state <= ST_IDLE;
                r_exp   <= '0;
                r_match <= '0;
                locked  <= 1'b0;
                err_cnt <= '0;
                lap_cnt <= '0;
            end else if (sample_en) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_in_range) begin
                            r_exp   <= w_nxt;
                            r_match <= '0;
                            r_state <= ST_SYNC;
                        end
                    end
                    ST_SYNC: begin
                        if (w_hit) begin
                            r_exp <= w_nxt;
                            if (r_match == C_LAST_MATCH) begin
                                // The wrap sample that completes lock is not a lap.
                                r_match <= '0;
                                r_state <= ST_TRACK;
                                locked  <= 1'b1;
                            end else begin
                                r_match <= r_match + 1'b1;
                            end
                        end else if (w_in_range) begin
                            r_exp   <= w_nxt;
                            r_match <= '0;
                        end else begin
                            r_match <= '0;
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_TRACK: begin
                        if (w_hit) begin
                            r_exp <= w_nxt;
                            // exp can only be 0 after a MAX_VAL sample.
                            if (cnt_in == '0) begin
                                lap_pulse <= 1'b1;
                                lap_cnt   <= lap_cnt + 1'b1;
                            end
                        end else begin
                            err_pulse <= 1'b1;
                            if (err_cnt != '1) begin
                                err_cnt <= err_cnt + 1'b1;
                            end
                            locked  <= 1'b0;
                            r_match <= '0;
                            if (w_in_range) begin
                                r_exp   <= w_nxt;
                                r_state <= ST_SYNC;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_match <= '0;
                        locked  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_loop_cnt_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_loop_cnt_monitor
// Purpose  : Self-checking bench for loop_cnt_monitor. A chain-length model
//            predicts every output each cycle; directed literals pin it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_loop_cnt_monitor;

    localparam int CNT_W    = 7;
    localparam int MAX_VAL  = 99;
    localparam int SYNC_LEN = 4;
    localparam int LAP_W    = 8;
    localparam int ERR_W    = 8;
    localparam int ERR_MAX  = (1 << ERR_W) - 1;
    localparam int LAP_MOD  = (1 << LAP_W);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [CNT_W-1:0] cnt_in = '0;
    logic             sample_en = 1'b0;
    logic             clr = 1'b0;
    logic             locked;
    logic             err_pulse;
    logic             lap_pulse;
    logic [ERR_W-1:0] err_cnt;
    logic [LAP_W-1:0] lap_cnt;

    int checks = 0;
    int errors = 0;

    // Model: length of the current run of valid successive samples. Locked
    // means the run holds at least SYNC_LEN+1 samples.
    int m_chain   = 0;
    int m_prev    = 0;
    int m_locked  = 0;
    int m_err_p   = 0;
    int m_lap_p   = 0;
    int m_err_cnt = 0;
    int m_lap_cnt = 0;

    loop_cnt_monitor #(
        .CNT_W   (CNT_W),
        .MAX_VAL (MAX_VAL),
        .SYNC_LEN(SYNC_LEN),
        .LAP_W   (LAP_W),
        .ERR_W   (ERR_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cnt_in   (cnt_in),
        .sample_en(sample_en),
        .clr      (clr),
        .locked   (locked),
        .err_pulse(err_pulse),
        .lap_pulse(lap_pulse),
        .err_cnt  (err_cnt),
        .lap_cnt  (lap_cnt)
    );

    always #5 clk = ~clk;

    function automatic int nxt(input int x);
        return (x == MAX_VAL) ? 0 : x + 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_chain = 0; m_prev = 0; m_locked = 0; m_err_p = 0; m_lap_p = 0;
        m_err_cnt = 0; m_lap_cnt = 0;
    endtask

    task automatic model_step();
        int  x;
        bit  cont;
        bit  was_locked;
        m_err_p = 0;
        m_lap_p = 0;
        if (clr) begin
            m_chain = 0; m_locked = 0; m_err_cnt = 0; m_lap_cnt = 0;
        end else if (sample_en) begin
            x          = int'(cnt_in);
            was_locked = (m_chain >= SYNC_LEN + 1);
            cont       = (m_chain > 0) && (x <= MAX_VAL) && (x == nxt(m_prev));
            if (cont) m_chain++;
            else      m_chain = (x <= MAX_VAL) ? 1 : 0;
            if (was_locked && !cont) begin
                m_err_p = 1;
                if (m_err_cnt < ERR_MAX) m_err_cnt++;
            end
            if (was_locked && cont && x == 0) begin
                m_lap_p   = 1;
                m_lap_cnt = (m_lap_cnt + 1) % LAP_MOD;
            end
            m_prev   = x;
            m_locked = (m_chain >= SYNC_LEN + 1) ? 1 : 0;
        end
    endtask

    // Model update at every active edge and on asynchronous reset.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // Compare every output against the model on the inactive edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("locked",    32'(locked),    32'(m_locked));
            chk("err_pulse", 32'(err_pulse), 32'(m_err_p));
            chk("lap_pulse", 32'(lap_pulse), 32'(m_lap_p));
            chk("err_cnt",   32'(err_cnt),   32'(m_err_cnt));
            chk("lap_cnt",   32'(lap_cnt),   32'(m_lap_cnt));
        end
    end

    // One clock with the given inputs; returns 1 time unit after the edge.
    task automatic cyc(input bit en, input int x, input bit c);
        sample_en = en;
        cnt_in    = x[CNT_W-1:0];
        clr       = c;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        clr       = 1'b0;
    endtask

    task automatic samp(input int x);
        cyc(1'b1, x, 1'b0);
    endtask

    task automatic do_clr();
        cyc(1'b0, 0, 1'b1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int v;
        int r;
        int y;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_locked",  32'(locked),  32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_lap_cnt", 32'(lap_cnt), 32'd0);
        rst_n = 1'b1;
        cyc(1'b0, 0, 1'b0);

        // Lock after 5 samples.
        for (int i = 10; i <= 13; i++) samp(i);
        chk("lock_not_yet", 32'(locked), 32'd0);
        samp(14);
        chk("lock_after_5", 32'(locked), 32'd1);
        chk("lock_err_cnt", 32'(err_cnt), 32'd0);

        // Lap on 99->0 while locked.
        do_clr();
        for (int i = 94; i <= 98; i++) samp(i);
        samp(99);
        chk("lap_no_pulse_99", 32'(lap_pulse), 32'd0);
        samp(0);
        chk("lap_pulse", 32'(lap_pulse), 32'd1);
        chk("lap_cnt_1", 32'(lap_cnt), 32'd1);
        samp(1);
        chk("lap_pulse_single", 32'(lap_pulse), 32'd0);

        // 300 samples from 0 while locked: three wraps.
        do_clr();
        for (int i = 95; i <= 99; i++) samp(i);
        for (int i = 0; i < 300; i++) samp(i % 100);
        chk("lap_cnt_3", 32'(lap_cnt), 32'd3);

        // Asynchronous reset mid-operation.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_locked",  32'(locked),  32'd0);
        chk("async_lap_cnt", 32'(lap_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Error while locked, then relock.
        for (int i = 16; i <= 20; i++) samp(i);
        samp(21);
        samp(25);
        chk("err_pulse", 32'(err_pulse), 32'd1);
        chk("err_cnt_1", 32'(err_cnt), 32'd1);
        chk("err_unlock", 32'(locked), 32'd0);
        samp(26);
        chk("err_pulse_single", 32'(err_pulse), 32'd0);
        samp(27);
        samp(28);
        chk("relock_not_yet", 32'(locked), 32'd0);
        samp(29);
        chk("relock", 32'(locked), 32'd1);

        // Out-of-range then stall.
        samp(120);
        chk("oor_err_cnt", 32'(err_cnt), 32'd2);
        samp(5);
        samp(5);
        chk("stall_no_lock", 32'(locked), 32'd0);
        chk("stall_no_err",  32'(err_cnt), 32'd2);

        // clr with sample_en in the same cycle while locked.
        for (int i = 40; i <= 44; i++) samp(i);
        cyc(1'b1, 45, 1'b1);
        chk("clr_locked",  32'(locked),  32'd0);
        chk("clr_err_cnt", 32'(err_cnt), 32'd0);
        samp(46);
        samp(47);
        samp(48);
        samp(49);
        chk("clr_sample_ignored", 32'(locked), 32'd0);

        // Error counter saturation.
        do_clr();
        for (int i = 0; i <= 4; i++) samp(i);
        v = 4;
        for (int k = 0; k < 300; k++) begin
            y = (v + 50) % 100;
            samp(y);
            for (int j = 0; j < SYNC_LEN; j++) begin
                y = nxt(y);
                samp(y);
            end
            v = y;
        end
        chk("err_saturate", 32'(err_cnt), 32'd255);

        // Randomised phase: mostly a healthy counter with occasional faults.
        v = 0;
        for (int n = 0; n < 4000; n++) begin
            r = int'($urandom_range(0, 999));
            if (r < 100) begin
                cyc(1'b0, int'($urandom_range(0, 127)), 1'b0);
            end else if (r < 940) begin
                v = nxt(v);
                samp(v);
            end else if (r < 960) begin
                v = int'($urandom_range(0, MAX_VAL));
                samp(v);
            end else if (r < 980) begin
                samp(v);
            end else if (r < 995) begin
                samp(int'($urandom_range(MAX_VAL + 1, 127)));
            end else begin
                cyc(1'($urandom_range(0, 1)), v, 1'b1);
            end
        end

        cyc(1'b0, 0, 1'b0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
